threshold_pool: RTL and testbench
=================================

# threshold_pool

Downstream neighbour of the popcount accumulator: consumes its NO_CH signed per-channel sums, applies a per-channel folded batch-norm threshold to produce binary activations, and max-pools those bits over POOL_LEN consecutive valid vectors. The result is an NO_CH-bit packed activation word for the next binarized layer. Thresholds are runtime-loadable through a simple write port.

## Interface
- NO_CH, 64: channel count.
- BW_IN, 16: signed width of each input sum and of each threshold.
- POOL_LEN, 4: vectors per pooling window, ≥1.
- clk  in  1  clock. One clock domain; reset is synchronous and active-high (rst).
- rst  in  1  synchronous active-high reset.
- vld_in  in  1  data_in valid this cycle.
- data_in  in  [NO_CH-1:0][BW_IN-1:0]  signed accumulator sums.
- last_in  in  1  qualified by vld_in; this beat closes the current window early.
- thr_wr_en  in  1  threshold write strobe.
- thr_wr_addr  in  $clog2(NO_CH)  channel index.
- thr_wr_data  in  BW_IN  signed threshold.
- thr_wr_flip  in  1  1 selects the inverted comparison (negative BN gamma).
- vld_out  out  1  single-cycle pulse; data_out holds a new pooled word.
- data_out  out  NO_CH  pooled binary activations, bit i = channel i.

## Operation
- Per-channel table entry {flip, thr}. All entries reset to {0, 0}.
- Write: on a cycle with thr_wr_en=1, the entry at thr_wr_addr is updated at that edge. thr_wr_addr ≥ NO_CH is ignored.
- Compare, signed: b_i = flip_i ? (data_in[i] < thr_i) : (data_in[i] >= thr_i).
- A write and a vld_in in the same cycle: that beat is compared against the old entry. The new value applies from the next cycle.
- Stage 1 registers the bit vector and the valid/last qualifiers.
- Pool stage with window counter cnt, 0..POOL_LEN-1, counter width max(1, $clog2(POOL_LEN)).
  - Beat with cnt=0: pool_reg <= b.
  - Other beats: pool_reg <= pool_reg | b. OR is max over the {0:-1, 1:+1} encoding.
  - A beat closes the window when cnt=POOL_LEN-1 or last=1. On close: cnt <= 0, data_out <= the pooled value including that beat, vld_out pulses.
  - Otherwise cnt <= cnt+1.
- No vld_in means no state change. Gaps within a window are allowed; the window counts valid beats only.
- POOL_LEN=1: every valid beat closes a window, giving pure thresholding.
- A partial window via last_in still emits exactly one word. The next beat starts a fresh window.
- No back-pressure. The consumer must accept every vld_out.

## Timing
- Reset values: vld_out=0, data_out=0, cnt=0, pool_reg=0, stage-1 valid=0, threshold table {0, 0}.
- Latency: the closing beat sampled at edge E gives vld_out=1 in the cycle after edge E+1, i.e. 2 cycles after the beat.
- vld_out is high for exactly one cycle per window.
- data_out is stable until the next window closes.
- Throughput: one input vector per cycle sustained.
- Minimum output spacing is POOL_LEN cycles without last_in, 1 cycle with last_in every beat.
- rst mid-window: the partial window is discarded with no output. An in-flight stage-1 beat is dropped. Thresholds are cleared.
- Threshold writes need not be quiesced. Per-beat semantics are as stated in Operation.

## Structure
- Package radio_bnn_pkg holds:
  - typedef thr_entry_t {logic flip; logic signed [BW_IN-1:0] thr;}
  - localparam function for the counter width.
- Sub-module binary_maxpool, parameterised NO_CH and POOL_LEN. It contains cnt, pool_reg, close logic, vld_out and data_out.
- threshold_pool holds the threshold table, the compare array and stage 1, and instantiates binary_maxpool.

## Test plan
- Reset, no writes, POOL_LEN=1, ch0 = +5, ch1 = -1, others 0 -> 2 cycles later vld_out=1, bit0=1, bit1=0, others 1 (0≥0).
- thr[3]={0, 100}, feed ch3 = 99, 100, 101 with POOL_LEN=1 -> bit3 = 0, 1, 1. Then thr[3]={1, 100}, same inputs -> bit3 = 1, 0, 0.
- POOL_LEN=4, ch7 set only on beat 3 of 4, with 2 idle cycles inserted between beats -> one vld_out after the 4th beat, bit7=1. Next window with ch7 always low -> bit7=0.
- POOL_LEN=4, last_in on beat 2 -> output after beat 2 holds the OR of 2 beats. The following 4 beats form a full window and give a single output.
- Write thr[0]={0, 50} in the same cycle as vld_in with ch0=40 -> bit0=1 (old thr 0 used). Next beat ch0=40 -> bit0=0.
- Assert rst after 3 of 4 beats -> no vld_out, data_out=0. A fresh 4-beat window then outputs correctly, and thresholds read back as {0, 0}.

Source files
------------

// File: rtl/radio_bnn_pkg.sv
// Shared types for the binarized radio pipeline.
// Threshold table entries and pool counter sizing.
package radio_bnn_pkg;

  localparam int NO_CH_D    = 64;
  localparam int BW_IN_D    = 16;
  localparam int POOL_LEN_D = 4;

  typedef struct packed {
    logic                      flip;
    logic signed [BW_IN_D-1:0] thr;
  } thr_entry_t;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/binary_maxpool.sv
// Max-pools binary activations over POOL_LEN valid beats.
// An early last closes a partial window.
module binary_maxpool
  import radio_bnn_pkg::*;
#(
  parameter int NO_CH    = NO_CH_D,
  parameter int POOL_LEN = POOL_LEN_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  input  logic             i_last,
  input  logic [NO_CH-1:0] i_bits,
  output logic             o_vld,
  output logic [NO_CH-1:0] o_data
);

  localparam int CW = cnt_width(POOL_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(POOL_LEN - 1);

  logic [CW-1:0]    r_cnt;
  logic [NO_CH-1:0] r_pool;
  logic             w_close;
  logic [NO_CH-1:0] w_pool;

  // OR is max under the {0:-1, 1:+1} encoding
  assign w_pool  = (r_cnt == '0) ? i_bits : (r_pool | i_bits);
  assign w_close = (r_cnt == LAST_CNT) || i_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_pool <= '0;
      o_vld  <= 1'b0;
      o_data <= '0;
    end else begin
      o_vld <= 1'b0;
      if (i_vld) begin
        r_pool <= w_pool;
        if (w_close) begin
          r_cnt  <= '0;
          o_data <= w_pool;
          o_vld  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/threshold_pool.sv
// Folded batch-norm thresholding of accumulator sums,
// followed by binary max-pooling.
module threshold_pool
  import radio_bnn_pkg::*;
#(
  parameter int NO_CH    = NO_CH_D,
  parameter int BW_IN    = BW_IN_D,
  parameter int POOL_LEN = POOL_LEN_D
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              vld_in,
  input  logic [NO_CH-1:0][BW_IN-1:0]       data_in,
  input  logic                              last_in,
  input  logic                              thr_wr_en,
  input  logic [$clog2(NO_CH)-1:0]          thr_wr_addr,
  input  logic [BW_IN-1:0]                  thr_wr_data,
  input  logic                              thr_wr_flip,
  output logic                              vld_out,
  output logic [NO_CH-1:0]                  data_out
);

  localparam int AW = $clog2(NO_CH);

  thr_entry_t       r_tbl [NO_CH];
  logic [NO_CH-1:0] w_bits;
  logic [NO_CH-1:0] r_bits;
  logic             r_vld;
  logic             r_last;
  logic             w_wr_ok;

  if ((2 ** AW) > NO_CH) begin : g_addr_chk
    assign w_wr_ok = thr_wr_en && (thr_wr_addr < AW'(NO_CH));
  end else begin : g_addr_full
    assign w_wr_ok = thr_wr_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NO_CH; i++) r_tbl[i] <= '0;
    end else if (w_wr_ok) begin
      r_tbl[thr_wr_addr] <= '{flip: thr_wr_flip,
                              thr:  thr_wr_data};
    end
  end

  // flip covers a negative BN gamma
  always_comb begin
    w_bits = '0;
    for (int i = 0; i < NO_CH; i++) begin
      if (r_tbl[i].flip)
        w_bits[i] = $signed(data_in[i]) < r_tbl[i].thr;
      else
        w_bits[i] = $signed(data_in[i]) >= r_tbl[i].thr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bits <= '0;
      r_vld  <= 1'b0;
      r_last <= 1'b0;
    end else begin
      r_vld  <= vld_in;
      r_last <= vld_in & last_in;
      if (vld_in) r_bits <= w_bits;
    end
  end

  binary_maxpool #(
    .NO_CH    (NO_CH),
    .POOL_LEN (POOL_LEN)
  ) u_pool (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (r_vld),
    .i_last (r_last),
    .i_bits (r_bits),
    .o_vld  (vld_out),
    .o_data (data_out)
  );

endmodule

// File: tb/tb_threshold_pool.sv
// Directed bench for threshold_pool with a pooled-word scoreboard.
// A reference model predicts each window's word.
module tb_threshold_pool;

  localparam int NC = 64;
  localparam int BW = 16;
  localparam int PL = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   vld_in;
  logic [NC-1:0][BW-1:0]  data_in;
  logic                   last_in;
  logic                   thr_wr_en;
  logic [5:0]             thr_wr_addr;
  logic [BW-1:0]          thr_wr_data;
  logic                   thr_wr_flip;
  logic                   vld_out;
  logic [NC-1:0]          data_out;

  threshold_pool #(.NO_CH(NC), .BW_IN(BW), .POOL_LEN(PL)) dut (
    .clk         (clk),
    .rst         (rst),
    .vld_in      (vld_in),
    .data_in     (data_in),
    .last_in     (last_in),
    .thr_wr_en   (thr_wr_en),
    .thr_wr_addr (thr_wr_addr),
    .thr_wr_data (thr_wr_data),
    .thr_wr_flip (thr_wr_flip),
    .vld_out     (vld_out),
    .data_out    (data_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_outs   = 0;

  logic [NC-1:0]     q [$];
  logic              m_flip [NC];
  logic signed [BW-1:0] m_thr [NC];
  int                m_cnt;
  logic [NC-1:0]     m_pool;
  logic [NC-1:0][BW-1:0] d;

  task automatic chk(input string tag, input logic [NC-1:0] obs,
                     input logic [NC-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (vld_out === 1'b1) begin
      n_outs++;
      n_checks++;
      assert (q.size() != 0) else begin
        n_errors++;
        $error("FAIL unexpected_out: observed %h expected none",
               data_out);
      end
      if (q.size() != 0) begin
        logic [NC-1:0] e;
        e = q.pop_front();
        n_checks++;
        assert (data_out === e) else begin
          n_errors++;
          $error("FAIL sb_word: observed %h expected %h", data_out, e);
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_flip[i] = 1'b0;
      m_thr[i]  = '0;
    end
    m_cnt  = 0;
    m_pool = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else if (thr_wr_en) begin
      m_flip[thr_wr_addr] = thr_wr_flip;
      m_thr[thr_wr_addr]  = thr_wr_data;
    end
    vld_in    = 1'b0;
    last_in   = 1'b0;
    thr_wr_en = 1'b0;
  endtask

  task automatic set_wr(input int a, input logic f, input int t);
    thr_wr_en   = 1'b1;
    thr_wr_addr = 6'(a);
    thr_wr_flip = f;
    thr_wr_data = BW'(t);
  endtask

  task automatic beat(input logic lst);
    logic [NC-1:0] b;
    logic [NC-1:0] p;
    for (int i = 0; i < NC; i++) begin
      logic signed [BW-1:0] x;
      x = d[i];
      b[i] = m_flip[i] ? (x < m_thr[i]) : (x >= m_thr[i]);
    end
    p = (m_cnt == 0) ? b : (m_pool | b);
    if (m_cnt == PL - 1 || lst) begin
      q.push_back(p);
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    m_pool  = p;
    vld_in  = 1'b1;
    last_in = lst;
    data_in = d;
    tick();
  endtask

  task automatic wait_out(input string tag);
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (vld_out) seen = 1;
    end
    n_checks++;
    assert (seen) else begin
      n_errors++;
      $error("FAIL %s_timeout: observed no vld_out expected pulse", tag);
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; vld_in = 0; last_in = 0; data_in = '0;
    thr_wr_en = 0; thr_wr_addr = '0; thr_wr_data = '0; thr_wr_flip = 0;
    d = '0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_vld", NC'(vld_out), '0);
    chk("rst_data", data_out, '0);

    d = '0; d[0] = 16'sd5; d[1] = -16'sd1;
    beat(1'b1);
    wait_out("t1");
    chk("t1_word", data_out, 64'hFFFF_FFFF_FFFF_FFFD);

    set_wr(3, 1'b0, 100); tick();
    d = '0; d[3] = 16'sd99;  beat(1'b1); wait_out("t2a");
    chk("t2a_b3", NC'(data_out[3]), NC'(1'b0));
    d[3] = 16'sd100; beat(1'b1); wait_out("t2b");
    chk("t2b_b3", NC'(data_out[3]), NC'(1'b1));
    d[3] = 16'sd101; beat(1'b1); wait_out("t2c");
    chk("t2c_b3", NC'(data_out[3]), NC'(1'b1));
    set_wr(3, 1'b1, 100); tick();
    d[3] = 16'sd99;  beat(1'b1); wait_out("t3a");
    chk("t3a_b3", NC'(data_out[3]), NC'(1'b1));
    d[3] = 16'sd100; beat(1'b1); wait_out("t3b");
    chk("t3b_b3", NC'(data_out[3]), NC'(1'b0));
    d[3] = 16'sd101; beat(1'b1); wait_out("t3c");
    chk("t3c_b3", NC'(data_out[3]), NC'(1'b0));

    for (int k = 0; k < 4; k++) begin
      d = '0;
      d[7] = (k == 2) ? 16'sd1 : -16'sd1;
      beat(1'b0);
      if (k != 3) begin tick(); tick(); end
    end
    wait_out("t4");
    chk("t4_b7", NC'(data_out[7]), NC'(1'b1));
    d = '0; d[7] = -16'sd3;
    for (int k = 0; k < 4; k++) beat(1'b0);
    wait_out("t4n");
    chk("t4n_b7", NC'(data_out[7]), NC'(1'b0));

    d = '0; d[7] = 16'sd2; d[9] = -16'sd1; beat(1'b0);
    d[7] = -16'sd2; beat(1'b1);
    wait_out("t5");
    chk("t5_b7", NC'(data_out[7]), NC'(1'b1));
    d = '0; d[7] = -16'sd2; d[9] = -16'sd1;
    for (int k = 0; k < 4; k++) beat(1'b0);
    wait_out("t5f");
    chk("t5f_b7", NC'(data_out[7]), NC'(1'b0));
    chk("t5f_b9", NC'(data_out[9]), NC'(1'b0));

    d = '0; d[0] = 16'sd40;
    set_wr(0, 1'b0, 50); beat(1'b1); wait_out("t6a");
    chk("t6a_b0", NC'(data_out[0]), NC'(1'b1));
    beat(1'b1); wait_out("t6b");
    chk("t6b_b0", NC'(data_out[0]), NC'(1'b0));

    begin
      int outs0;
      d = '0; d[0] = -16'sd4;
      for (int k = 0; k < 3; k++) beat(1'b0);
      outs0 = n_outs;
      rst = 1'b1; tick(); tick();
      rst = 1'b0;
      q.delete();
      tick(); tick(); tick();
      chk("rst_mid_data", data_out, '0);
      chk("rst_mid_nout", NC'(n_outs - outs0), '0);
    end
    d = '0; d[0] = 16'sd40; d[1] = -16'sd1; d[3] = 16'sd99;
    for (int k = 0; k < 4; k++) beat(1'b0);
    wait_out("t7");
    chk("t7_word", data_out, 64'hFFFF_FFFF_FFFF_FFFD);

    tick(); tick(); tick();
    chk("sb_empty", NC'(q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
